// File: rtl/fnb_a_streamer.sv
// Activation streamer: holds one full activation vector and replays it as BEATS beats of PIPE_SIZE activations.
// Optional macro FNB_A_STREAMER_LAST_EN adds out_last, marking the final beat of each vector.
module fnb_a_streamer #(
    parameter int A_WIDTH        = 18,
    parameter int NUM_OF_NUERONS = 4,
    parameter int PIPE_SIZE      = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_mat_valid,
    output logic                                in_mat_rdy,
    input  logic [A_WIDTH*NUM_OF_NUERONS-1:0]   in_mat_data,
    output logic                                out_st_valid,
    input  logic                                out_st_rdy,
    output logic [A_WIDTH*PIPE_SIZE-1:0]        out_st_data,
    output logic                                done,
    output logic                                irq
`ifdef FNB_A_STREAMER_LAST_EN
    ,
    output logic                                out_last
`endif
);

    localparam int BEATS = NUM_OF_NUERONS / PIPE_SIZE;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BW    = A_WIDTH * PIPE_SIZE;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b01,
        STREAM = 2'b10
    } state_t;

    state_t                              state;
    logic [CW-1:0]                       cnt;
    logic [A_WIDTH*NUM_OF_NUERONS-1:0]   hold;
    logic                                last_beat;

    // Handshake outputs are decoded from state but forced low while reset is held.
    assign in_mat_rdy   = !rst && (state == IDLE);
    assign out_st_valid = !rst && (state == STREAM);
    assign last_beat    = (cnt == LAST);
    assign done         = out_st_valid && out_st_rdy && last_beat;

`ifdef FNB_A_STREAMER_LAST_EN
    assign out_last = out_st_valid && last_beat;
`endif

    always_comb begin
        out_st_data = '0;
        for (int unsigned b = 0; b < BEATS; b++) begin
            if (cnt == CW'(b)) begin
                out_st_data = hold[b*BW +: BW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            irq   <= 1'b0;
            hold  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_mat_valid) begin
                        hold  <= in_mat_data;
                        cnt   <= '0;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (out_st_rdy) begin
                        if (last_beat) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    // Any non one-hot encoding is a fault: recover to IDLE and latch irq until reset.
                    irq   <= 1'b1;
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fnb_a_streamer.sv
// Bench for fnb_a_streamer: two instances (PIPE_SIZE 1 and 2) checked every cycle against a queue-based model.
// Optional macro FNB_A_STREAMER_LAST_EN also checks out_last.
module tb_fnb_a_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        chk_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          a_xfers = 0;

    logic        a_iv, a_irdy, a_ov, a_ordy, a_done, a_irq;
    logic [71:0] a_id;
    logic [17:0] a_od;
    logic        b_iv, b_irdy, b_ov, b_ordy, b_done, b_irq;
    logic [71:0] b_id;
    logic [35:0] b_od;
`ifdef FNB_A_STREAMER_LAST_EN
    logic        a_last, b_last;
`endif

    logic [17:0] qa[$];
    logic [35:0] qb[$];

    always #5 clk = ~clk;

    fnb_a_streamer #(.A_WIDTH(18), .NUM_OF_NUERONS(4), .PIPE_SIZE(1)) dut_a (
        .clk(clk), .rst(rst),
        .in_mat_valid(a_iv), .in_mat_rdy(a_irdy), .in_mat_data(a_id),
        .out_st_valid(a_ov), .out_st_rdy(a_ordy), .out_st_data(a_od),
        .done(a_done), .irq(a_irq)
`ifdef FNB_A_STREAMER_LAST_EN
        , .out_last(a_last)
`endif
    );

    fnb_a_streamer #(.A_WIDTH(18), .NUM_OF_NUERONS(4), .PIPE_SIZE(2)) dut_b (
        .clk(clk), .rst(rst),
        .in_mat_valid(b_iv), .in_mat_rdy(b_irdy), .in_mat_data(b_id),
        .out_st_valid(b_ov), .out_st_rdy(b_ordy), .out_st_data(b_od),
        .done(b_done), .irq(b_irq)
`ifdef FNB_A_STREAMER_LAST_EN
        , .out_last(b_last)
`endif
    );

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [71:0] vec4(input int n0, input int n1, input int n2, input int n3);
        return {18'(n3), 18'(n2), 18'(n1), 18'(n0)};
    endfunction

    // Model: a vector becomes a queue of beats; the head beat is what must be on the output.
    always @(posedge clk) begin
        if (!rst && a_ov && a_ordy) a_xfers++;
        if (rst) begin
            qa.delete();
            qb.delete();
        end else begin
            if (qa.size() == 0) begin
                if (a_iv) for (int k = 0; k < 4; k++) qa.push_back(a_id[k*18 +: 18]);
            end else if (a_ordy) begin
                void'(qa.pop_front());
            end
            if (qb.size() == 0) begin
                if (b_iv) for (int k = 0; k < 2; k++) qb.push_back(b_id[k*36 +: 36]);
            end else if (b_ordy) begin
                void'(qb.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_rdy",   72'(a_irdy), 72'(!rst && qa.size() == 0));
            chk("a_valid", 72'(a_ov),   72'(!rst && qa.size() != 0));
            chk("a_done",  72'(a_done), 72'(!rst && a_ordy && qa.size() == 1));
            chk("a_irq",   72'(a_irq),  72'(0));
            if (!rst && qa.size() != 0) chk("a_data", 72'(a_od), 72'(qa[0]));
            chk("b_rdy",   72'(b_irdy), 72'(!rst && qb.size() == 0));
            chk("b_valid", 72'(b_ov),   72'(!rst && qb.size() != 0));
            chk("b_done",  72'(b_done), 72'(!rst && b_ordy && qb.size() == 1));
            chk("b_irq",   72'(b_irq),  72'(0));
            if (!rst && qb.size() != 0) chk("b_data", 72'(b_od), 72'(qb[0]));
`ifdef FNB_A_STREAMER_LAST_EN
            chk("a_last", 72'(a_last), 72'(!rst && qa.size() == 1));
            chk("b_last", 72'(b_last), 72'(!rst && qb.size() == 1));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int x0;
        rst = 1'b1;
        a_iv = 1'b0; a_id = '0; a_ordy = 1'b0;
        b_iv = 1'b0; b_id = '0; b_ordy = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_a_rdy",   72'(a_irdy), 72'(0));
        chk("rst_a_valid", 72'(a_ov),   72'(0));
        tick();
        rst = 1'b0;
        chk_en = 1'b1;

        // Four beats in order, done on the last, ready again right after.
        a_ordy = 1'b1; a_iv = 1'b1; a_id = vec4(1, 2, 3, 4);
        @(negedge clk);
        chk("lit_acc_rdy", 72'(a_irdy), 72'(1));
        for (int k = 1; k <= 4; k++) begin
            tick();
            a_iv = 1'b0;
            @(negedge clk);
            chk("lit_beat",   72'(a_od),   72'(k));
            chk("lit_m_beat", 72'(qa[0]),  72'(k));
            chk("lit_done",   72'(a_done), 72'(k == 4));
        end
        tick();
        @(negedge clk);
        chk("lit_idle_rdy", 72'(a_irdy), 72'(1));

        // Back-pressure on beat 1, plus an in_valid pulse during STREAM that must be ignored.
        x0 = a_xfers;
        a_iv = 1'b1; a_id = vec4(1, 2, 3, 4); a_ordy = 1'b1;
        tick();
        a_iv = 1'b0;
        @(negedge clk);
        chk("bp_beat0", 72'(a_od), 72'(1));
        for (int k = 0; k < 3; k++) begin
            tick();
            a_ordy = 1'b0;
            a_iv = (k == 0);
            a_id = vec4(9, 9, 9, 9);
            @(negedge clk);
            chk("bp_hold",  72'(a_od), 72'(2));
            chk("bp_valid", 72'(a_ov), 72'(1));
            chk("bp_rdy",   72'(a_irdy), 72'(0));
        end
        for (int k = 2; k <= 4; k++) begin
            tick();
            a_ordy = 1'b1; a_iv = 1'b0;
            @(negedge clk);
            chk("bp_beat", 72'(a_od), 72'(k));
        end
        tick();
        @(negedge clk);
        chk("bp_xfers", 72'(a_xfers - x0), 72'(4));

        // Reset mid-vector: remaining beats vanish, a new vector starts from beat 0.
        a_iv = 1'b1; a_id = vec4(1, 2, 3, 4); a_ordy = 1'b1;
        tick(); a_iv = 1'b0;
        tick();
        @(negedge clk);
        chk("rs_beat1", 72'(a_od), 72'(2));
        tick(); rst = 1'b1;
        @(negedge clk);
        chk("rs_valid", 72'(a_ov), 72'(0));
        tick(); rst = 1'b0; a_iv = 1'b1; a_id = vec4(5, 6, 7, 8);
        @(negedge clk);
        chk("rs_rdy", 72'(a_irdy), 72'(1));
        tick(); a_iv = 1'b0;
        @(negedge clk);
        chk("rs_new_beat0", 72'(a_od), 72'(5));
        repeat (4) tick();

        // Two-activation beats: low neuron in the low 18 bits, done on beat 1.
        b_ordy = 1'b1; b_iv = 1'b1; b_id = vec4(18'h11, 18'h22, 18'h33, 18'h44);
        tick(); b_iv = 1'b0;
        @(negedge clk);
        chk("p2_beat0", 72'(b_od), 72'({18'h22, 18'h11}));
        chk("p2_m_beat0", 72'(qb[0]), 72'({18'h22, 18'h11}));
        chk("p2_done0", 72'(b_done), 72'(0));
        tick();
        @(negedge clk);
        chk("p2_beat1", 72'(b_od), 72'({18'h44, 18'h33}));
        chk("p2_done1", 72'(b_done), 72'(1));
        tick();

        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 79) == 0);
            a_iv   = 1'($urandom_range(0, 1));
            a_id   = 72'({$urandom(), $urandom(), $urandom()});
            a_ordy = ($urandom_range(0, 3) != 0);
            b_iv   = 1'($urandom_range(0, 1));
            b_id   = 72'({$urandom(), $urandom(), $urandom()});
            b_ordy = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst = 1'b0; a_iv = 1'b0; b_iv = 1'b0; a_ordy = 1'b1; b_ordy = 1'b1;
        repeat (6) tick();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fnb_a_streamer.md
FNB_A_STREAMER -- requirements
Module: fnb_a_streamer

Interface
REQ-001 SHALL have parameter A_WIDTH, default 18, width of one activation.
REQ-002 SHALL have parameter NUM_OF_NUERONS, default 4, activations per input vector.
REQ-003 SHALL have parameter PIPE_SIZE, default 1, activations per output beat; NUM_OF_NUERONS SHALL be a multiple of PIPE_SIZE, and BEATS = NUM_OF_NUERONS / PIPE_SIZE.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have port in_mat (dvr_if.slave): valid in 1, rdy out 1, data in A_WIDTH*NUM_OF_NUERONS, the full layer activation vector.
REQ-007 SHALL have port out_st (dvr_if.master): valid out 1, rdy in 1, data out A_WIDTH*PIPE_SIZE, the activation stream to the next layer's manager.
REQ-008 SHALL have port done, output, 1, one-cycle pulse on acceptance of the final beat.
REQ-009 SHALL have port irq, output, 1, sticky illegal-state flag.

Function
REQ-010 SHALL implement a one-hot state machine with states IDLE and STREAM, plus a beat counter cnt of log2up(BEATS) bits, minimum 1 bit.
REQ-011 In IDLE, in_mat.rdy SHALL be 1 and out_st.valid SHALL be 0.
REQ-012 In IDLE, when in_mat.valid=1, the block SHALL register in_mat.data into a hold register, clear cnt and enter STREAM on the next edge.
REQ-013 In STREAM, in_mat.rdy SHALL be 0, so in_mat.valid is ignored, and out_st.valid SHALL be 1.
REQ-014 Neuron k SHALL occupy in_mat.data bits [k*A_WIDTH +: A_WIDTH].
REQ-015 Beat b SHALL carry neurons b*PIPE_SIZE .. b*PIPE_SIZE+PIPE_SIZE-1, with the lowest-index neuron at the LSB of out_st.data.
REQ-016 out_st.data SHALL be driven from the hold register only and SHALL stay stable while out_st.valid=1 and out_st.rdy=0.
REQ-017 A beat transfers on a cycle where out_st.valid=1 and out_st.rdy=1. On transfer, if cnt<BEATS-1 then cnt SHALL increment; if cnt=BEATS-1 then cnt SHALL clear, the state SHALL return to IDLE and done SHALL be 1 in that cycle.
REQ-018 Latency: if the vector is accepted in cycle N, beat 0 SHALL be valid in cycle N+1.
REQ-019 Throughput: with rdy held high, one vector SHALL complete every BEATS+1 cycles.
REQ-020 When BEATS=1 (PIPE_SIZE=NUM_OF_NUERONS), STREAM SHALL last exactly one transfer.
REQ-021 out_st.rdy asserted before out_st.valid SHALL have no effect; cnt SHALL never advance without a transfer.
REQ-022 Any state encoding other than IDLE or STREAM SHALL set irq to 1 and force IDLE; irq SHALL hold at 1 until reset.

Reset
REQ-023 rst=1 SHALL, at the next edge, set state=IDLE, cnt=0, irq=0 and done=0, and clear the hold register to 0.
REQ-024 While rst=1, out_st.valid SHALL be 0 and in_mat.rdy SHALL be 0.
REQ-025 A reset during STREAM SHALL discard the rest of the vector, and no further beat of that vector SHALL appear.

Configuration
REQ-026 With macro FNB_A_STREAMER_LAST_EN defined, the block SHALL add output port out_last (1 bit). out_last SHALL be 1 exactly when out_st.valid=1 and cnt=BEATS-1, and 0 otherwise, including under reset.
REQ-027 Without FNB_A_STREAMER_LAST_EN, port out_last and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-028 A_WIDTH=18, NUM=4, PIPE=1, rdy=1; in_mat.data neurons {1,2,3,4} accepted at cycle N -> out_st.data 1,2,3,4 in cycles N+1..N+4, done=1 at N+4, in_mat.rdy=1 at N+5.
REQ-029 Same vector, rdy=0 for cycles N+2..N+4 -> beat 1 (value 2) held stable with valid=1 throughout; beats 2,3,4 follow once rdy=1; exactly 4 transfers.
REQ-030 PIPE=2, neurons {0x11,0x22,0x33,0x44} -> beat 0 = {0x22,0x11} (0x11 in the low 18 bits), beat 1 = {0x44,0x33}; done on beat 1.
REQ-031 rst=1 for one cycle after beat 1 of a 4-beat vector -> valid=0 next cycle, no beats 2 or 3, in_mat.rdy=1 in the following cycle, and a new vector streams from beat 0.
REQ-032 With FNB_A_STREAMER_LAST_EN, NUM=4, PIPE=1 -> out_last=1 only on the value-4 beat. With in_mat.valid pulsed during STREAM -> that data is not captured and the output is unchanged.
